// File: rtl/rhd_spi_cmd_master_pkg.sv
// Shared constants and state encoding for the RHD2000 SPI command master and its MISO capture.
package rhd_spi_cmd_master_pkg;

  localparam int RHD_WORD_BITS    = 16;
  localparam int RHD_OVERSAMPLE   = 4;
  localparam int RHD_SHIFT_CYCLES = RHD_WORD_BITS * RHD_OVERSAMPLE;
  localparam int RHD_TAIL_SAMPLES = 10;
  localparam int RHD_MISO4X_WIDTH = RHD_SHIFT_CYCLES + RHD_TAIL_SAMPLES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HIGH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/rhd_miso_capture.sv
// Samples MISO once per dataclk for one word plus its tail, then publishes the 74-sample window
// with a one-cycle valid pulse. Sample k ends up in bit k.
module rhd_miso_capture
  import rhd_spi_cmd_master_pkg::*;
(
  input  logic                        dataclk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        miso_in,
  output logic [RHD_MISO4X_WIDTH-1:0] miso4x,
  output logic                        miso4x_valid
);

  localparam int              CNT_W    = $clog2(RHD_MISO4X_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RHD_MISO4X_WIDTH - 1);

  logic [RHD_MISO4X_WIDTH-1:0] cap_q;
  logic [RHD_MISO4X_WIDTH-1:0] cap_shifted;
  logic [CNT_W-1:0]            cnt_q;
  logic                        active_q;

  assign cap_shifted = {miso_in, cap_q[RHD_MISO4X_WIDTH-1:1]};

  // NOTE: the capture register is reset too, so an aborted word can never leak stale samples.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      cap_q        <= '0;
      cnt_q        <= '0;
      active_q     <= 1'b0;
      miso4x       <= '0;
      miso4x_valid <= 1'b0;
    end else begin
      miso4x_valid <= 1'b0;
      if (start) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
      end else if (active_q) begin
        cap_q <= cap_shifted;
        if (cnt_q == LAST_CNT) begin
          active_q     <= 1'b0;
          miso4x       <= cap_shifted;
          miso4x_valid <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rhd_spi_cmd_master.sv
// SPI command master for one RHD2000 port: one 16-bit word per transaction, sclk = dataclk/4,
// registered cs_b/sclk/mosi, and a 4x-oversampled MISO window for the DDR phase selector.
module rhd_spi_cmd_master
  import rhd_spi_cmd_master_pkg::*;
#(
  parameter int CS_HIGH_CYCLES = 12
) (
  input  logic                        dataclk,
  input  logic                        reset,
  input  logic [RHD_WORD_BITS-1:0]    cmd_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic                        cs_b,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso_in,
  output logic [RHD_MISO4X_WIDTH-1:0] miso4x,
  output logic                        miso4x_valid,
  output logic                        busy
);

  localparam int PHASE_W = $clog2(RHD_OVERSAMPLE);
  localparam int BIT_W   = $clog2(RHD_WORD_BITS);
  localparam int GAP_W   = $clog2(CS_HIGH_CYCLES);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(RHD_OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] HIGH_PHASE = PHASE_W'(RHD_OVERSAMPLE / 2);
  localparam logic [BIT_W-1:0]   FIRST_BIT  = BIT_W'(RHD_WORD_BITS - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP   = GAP_W'(CS_HIGH_CYCLES - 1);

  // The capture tail runs into CS_HIGH; a shorter gap would let the next word restart it early.
  if (CS_HIGH_CYCLES < RHD_TAIL_SAMPLES) begin : g_bad_cs_high
    $error("CS_HIGH_CYCLES (%0d) must be >= %0d", CS_HIGH_CYCLES, RHD_TAIL_SAMPLES);
  end

  spi_state_t               state_q, state_d;
  logic [PHASE_W-1:0]       phase_q, phase_d, phase_nxt;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [RHD_WORD_BITS-1:0] shreg_q, shreg_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     cs_b_d, sclk_d, mosi_d, ready_d;
  logic                     start;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    gap_d     = gap_q;
    cs_b_d    = 1'b1;
    sclk_d    = 1'b0;
    mosi_d    = 1'b0;
    start     = 1'b0;
    phase_nxt = phase_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_SHIFT;
          phase_d = '0;
          bit_d   = FIRST_BIT;
          shreg_d = cmd_data;
          cs_b_d  = 1'b0;
          mosi_d  = cmd_data[RHD_WORD_BITS-1];
          start   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (phase_q == LAST_PHASE) begin
          if (bit_q == '0) begin
            state_d = ST_CS_HIGH;
            gap_d   = '0;
          end else begin
            phase_d = '0;
            bit_d   = bit_q - 1'b1;
            shreg_d = {shreg_q[RHD_WORD_BITS-2:0], 1'b0};
            cs_b_d  = 1'b0;
            mosi_d  = shreg_q[RHD_WORD_BITS-2];
          end
        end else begin
          phase_d = phase_nxt;
          cs_b_d  = 1'b0;
          mosi_d  = shreg_q[RHD_WORD_BITS-1];
          sclk_d  = (phase_nxt >= HIGH_PHASE);
        end
      end
      ST_CS_HIGH: begin
        if (gap_q == LAST_GAP) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only; outputs are registered here so
  // the asynchronous reset forces cs_b high without waiting for a clock edge.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      gap_q     <= '0;
      cs_b      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      gap_q     <= gap_d;
      cs_b      <= cs_b_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      cmd_ready <= ready_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  rhd_miso_capture u_capture (
    .dataclk      (dataclk),
    .reset        (reset),
    .start        (start),
    .miso_in      (miso_in),
    .miso4x       (miso4x),
    .miso4x_valid (miso4x_valid)
  );

endmodule

// File: tb/tb_rhd_spi_cmd_master.sv
// Directed bench for rhd_spi_cmd_master: scoreboarded MOSI bits and MISO windows, cs_b timing,
// back-to-back words and an asynchronous reset in the middle of a word.
module tb_rhd_spi_cmd_master;
  import rhd_spi_cmd_master_pkg::*;

  localparam int W   = RHD_MISO4X_WIDTH;
  localparam int CSH = 12;

  typedef struct {
    logic [15:0]  word;
    logic [W-1:0] pat;
    logic [W-1:0] exp;
  } job_t;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } cap_exp_t;

  logic         dataclk   = 1'b0;
  logic         reset     = 1'b1;
  logic [15:0]  cmd_data  = '0;
  logic         cmd_valid = 1'b0;
  logic         miso_in   = 1'b0;
  logic         cmd_ready, cs_b, sclk, mosi, miso4x_valid, busy;
  logic [W-1:0] miso4x;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int n_accept   = 0;
  int n_valid    = 0;
  int accept_cyc = 0;
  int last_gap   = 0;

  job_t     job_q[$];
  logic     mosi_q[$];
  cap_exp_t cap_q[$];

  rhd_spi_cmd_master #(.CS_HIGH_CYCLES(CSH)) dut (
    .dataclk      (dataclk),
    .reset        (reset),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cs_b         (cs_b),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso_in      (miso_in),
    .miso4x       (miso4x),
    .miso4x_valid (miso4x_valid),
    .busy         (busy)
  );

  always #5 dataclk = ~dataclk;
  always @(posedge dataclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Headstage model: on each accepted word, queue expected MOSI bits and MISO window, and
  // drive miso_in so that cycle T+1+k carries sample k.
  initial begin : headstage
    job_t         j;
    logic [W-1:0] pat;
    int           base;
    bit           active;
    pat = '0; base = 0; active = 0;
    forever begin
      @(negedge dataclk);
      if (reset) begin
        active  = 0;
        miso_in = 1'b0;
        mosi_q.delete();
        cap_q.delete();
      end else begin
        if (cmd_valid && cmd_ready) begin
          accept_cyc = cyc;
          n_accept++;
          if (job_q.size() == 0) check("accept_unplanned", cmd_valid, 1'b0);
          else begin
            j = job_q.pop_front();
            for (int b = 15; b >= 0; b--) mosi_q.push_back(j.word[b]);
            cap_q.push_back('{data: j.exp, cyc: cyc + 75});
            pat    = j.pat;
            base   = cyc + 1;
            active = 1;
          end
        end
        if (active && cyc >= base && cyc < base + W) miso_in = pat[cyc - base];
        else miso_in = 1'b0;
      end
    end
  end

  // SPI pin monitor: MOSI at each sclk rise, cs_b low width, rises per word, cs_b high gap.
  initial begin : pin_monitor
    logic prev_sclk, prev_cs_b;
    int   low_run, high_run, rises;
    prev_sclk = 1'b0; prev_cs_b = 1'b1; low_run = 0; high_run = 0; rises = 0;
    forever begin
      @(negedge dataclk);
      if (reset) begin
        prev_sclk = 1'b0; prev_cs_b = 1'b1; low_run = 0; high_run = 0; rises = 0;
      end else begin
        if (sclk && !prev_sclk) begin
          rises++;
          if (mosi_q.size() == 0) check("sclk_rise_unexpected", sclk, 1'b0);
          else check("mosi_bit", mosi, mosi_q.pop_front());
        end
        if (!cs_b) begin
          if (prev_cs_b) last_gap = high_run;
          low_run++;
          high_run = 0;
        end else begin
          if (!prev_cs_b) begin
            check("cs_low_cycles", low_run, 64);
            check("sclk_rises", rises, 16);
            low_run = 0;
            rises   = 0;
          end
          high_run++;
        end
        prev_sclk = sclk;
        prev_cs_b = cs_b;
      end
    end
  end

  initial begin : capture_monitor
    cap_exp_t e;
    forever begin
      @(negedge dataclk);
      if (!reset && miso4x_valid) begin
        n_valid++;
        if (cap_q.size() == 0) check("miso4x_valid_unexpected", miso4x_valid, 1'b0);
        else begin
          e = cap_q.pop_front();
          check("miso4x_valid_cycle", cyc, e.cyc);
          check("miso4x_data", miso4x, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge dataclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_accept(input int target);
    int budget;
    budget = 200;
    while (n_accept < target && budget > 0) begin
      tick();
      budget--;
    end
    check("accept_timeout", (n_accept >= target), 1'b1);
  endtask

  task automatic wait_done();
    int budget;
    budget = 300;
    while ((busy || cap_q.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("done_timeout", (!busy && cap_q.size() == 0), 1'b1);
  endtask

  task automatic send(input logic [15:0] word, input logic [W-1:0] pat, input logic [W-1:0] exp);
    job_q.push_back('{word: word, pat: pat, exp: exp});
    cmd_data  = word;
    cmd_valid = 1'b1;
    wait_accept(n_accept + 1);
    cmd_valid = 1'b0;
    cmd_data  = 16'($urandom);
  endtask

  initial begin : stimulus
    logic [W-1:0] p, p2;
    int           t1, nv;

    // Reset held 5 cycles
    ticks(5);
    check("rst_cs_b", cs_b, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_miso4x", miso4x, '0);
    check("rst_miso4x_valid", miso4x_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    check("cmd_ready_before_clock", cmd_ready, 1'b0);
    tick();
    check("cmd_ready_after_release", cmd_ready, 1'b1);

    // Single word, one MISO pulse at sample 6
    p = '0; p[6] = 1'b1;
    send(16'hA5C3, p, 74'h40);
    check("busy_in_word", busy, 1'b1);
    check("cmd_ready_in_word", cmd_ready, 1'b0);
    check("cs_b_first_shift_cycle", cs_b, 1'b0);
    wait_done();
    check("cmd_ready_after_word", cmd_ready, 1'b1);

    // MISO high on odd samples
    p = '0;
    for (int k = 1; k < W; k += 2) p[k] = 1'b1;
    send(16'h3C5A, p, 74'h2AA_AAAA_AAAA_AAAA_AAAA);
    wait_done();
    ticks(3);
    check("miso4x_holds", miso4x, 74'h2AA_AAAA_AAAA_AAAA_AAAA);

    // Back-to-back with cmd_valid held
    nv = n_valid;
    p  = '0;
    for (int k = 0; k < W; k += 2) p[k] = 1'b1;
    p2 = '1;
    job_q.push_back('{word: 16'h0001, pat: p, exp: 74'h155_5555_5555_5555_5555});
    job_q.push_back('{word: 16'h8000, pat: p2, exp: '1});
    cmd_data  = 16'h0001;
    cmd_valid = 1'b1;
    wait_accept(n_accept + 1);
    t1       = accept_cyc;
    cmd_data = 16'h8000;
    wait_accept(n_accept + 1);
    cmd_valid = 1'b0;
    check("b2b_accept_spacing", accept_cyc - t1, 64 + CSH + 1);
    tick();
    check("cs_high_gap", last_gap, CSH + 1);
    wait_done();
    check("b2b_valid_pulses", n_valid - nv, 2);

    // Asynchronous reset during bit 7 of a word
    p = '0; p[3] = 1'b1;
    send(16'h1234, p, 74'h8);
    t1 = accept_cyc;
    while (cyc < t1 + 34) tick();
    check("mid_word_cs_b_low", cs_b, 1'b0);
    check("miso4x_before_reset", miso4x, '1);
    nv = n_valid;
    #2 reset = 1'b1;
    #1;
    check("async_cs_b", cs_b, 1'b1);
    check("async_sclk", sclk, 1'b0);
    check("async_mosi", mosi, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_cmd_ready", cmd_ready, 1'b0);
    check("async_miso4x", miso4x, '0);
    ticks(3);
    reset = 1'b0;
    ticks(80);
    check("no_valid_after_reset", n_valid, nv);
    check("miso4x_cleared", miso4x, '0);

    // Normal word after reset; first and last sample positions
    p = '0; p[0] = 1'b1; p[W-1] = 1'b1;
    send(16'h5A0F, p, 74'h200_0000_0000_0000_0001);
    wait_done();
    check("post_reset_valid_pulse", n_valid, nv + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
